// File: rtl/can_fd_pkg.sv
// Shared types and widths for the CAN FD bit-rate-switch controller.
// Provides the controller state enum, the packed bit-timing set that
// can_btl consumes, and the field/counter widths.
package can_fd_pkg;

  localparam int unsigned PRESC_W  = 6;
  localparam int unsigned SJW_W    = 2;
  localparam int unsigned TSEG1_W  = 4;
  localparam int unsigned TSEG2_W  = 3;
  localparam int unsigned WD_CNT_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    NOMINAL,
    DATA
  } brs_state_e;

  typedef struct packed {
    logic [PRESC_W-1:0] presc;
    logic [SJW_W-1:0]   sjw;
    logic [TSEG1_W-1:0] tseg1;
    logic [TSEG2_W-1:0] tseg2;
    logic               tsmp;
  } timing_set_t;

endpackage

// File: rtl/can_brs_watchdog.sv
// Data-phase watchdog for can_fd_brs_ctrl (built only with
// CAN_FD_BRS_WATCHDOG_EN defined).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clear         - data phase is being entered; restart the count
//   active        - controller is currently in the data phase
//   sample_point  - BTL sample point strobe
//   expire        - this sample point reaches the MAX_DATA_BITS budget
`ifdef CAN_FD_BRS_WATCHDOG_EN
module can_brs_watchdog
  import can_fd_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 700
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic sample_point,
  output logic expire
);

  logic [WD_CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_CNT_W:0]   cnt_inc;

  // Expiry is combinational on the sample point that reaches the budget so
  // the controller leaves DATA on that same edge.
  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (WD_CNT_W+1)'(1);
    cnt_d   = cnt_q;
    expire  = active && sample_point &&
              (cnt_inc >= (WD_CNT_W+1)'(MAX_DATA_BITS));
    if (clear) begin
      cnt_d = '0;
    end else if (active && sample_point && (cnt_q != '1)) begin
      cnt_d = cnt_inc[WD_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/can_fd_brs_ctrl.sv
// Bit-rate-switch controller for the CAN FD receive path.
// Selects nominal timing during arbitration and data-phase timing between
// the BRS sample point and the CRC-delimiter sample point, and freezes both
// configuration sets for the length of a frame.
// Optional feature: define CAN_FD_BRS_WATCHDOG_EN to build a data-phase
// watchdog that aborts DATA after MAX_DATA_BITS sample points.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   baud_r_presc..triple_sampling - nominal-phase configuration
//   fd_*                          - data-phase configuration
//   en_FD_bit_rate_change         - bit-rate switching allowed
//   rx_idle, fdf, brs_field,
//   crc_delim_field, go_error_frame - frame status from can_bsp
//   sample_point, sampled_bit     - from can_btl
//   btl_*                         - registered timing fed to can_btl
//   data_phase                    - data-phase timing active
//   brs_switch                    - 1-cycle pulse on data-phase entry
//   brs_timeout                   - 1-cycle pulse on watchdog abort
module can_fd_brs_ctrl
  import can_fd_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] baud_r_presc,
  input  logic [1:0] sync_jump_width,
  input  logic [3:0] time_segment1,
  input  logic [2:0] time_segment2,
  input  logic       triple_sampling,
  input  logic [5:0] fd_baud_r_presc,
  input  logic [1:0] fd_sync_jump_width,
  input  logic [3:0] fd_time_segment1,
  input  logic [2:0] fd_time_segment2,
  input  logic       en_FD_bit_rate_change,
  input  logic       rx_idle,
  input  logic       fdf,
  input  logic       brs_field,
  input  logic       crc_delim_field,
  input  logic       sample_point,
  input  logic       sampled_bit,
  input  logic       go_error_frame,
  output logic [5:0] btl_baud_r_presc,
  output logic [1:0] btl_sync_jump_width,
  output logic [3:0] btl_time_segment1,
  output logic [2:0] btl_time_segment2,
  output logic       btl_triple_sampling,
  output logic       data_phase,
  output logic       brs_switch,
  output logic       brs_timeout
);

  brs_state_e  state_q, state_d;
  timing_set_t nom_q, nom_d;
  timing_set_t fd_q, fd_d;
  timing_set_t btl_q, btl_d;
  logic        data_phase_q, data_phase_d;
  logic        brs_switch_q, brs_switch_d;
  logic        brs_timeout_q, brs_timeout_d;

  timing_set_t nom_in, fd_in;
  logic        brs_ok;
  logic        wd_expire;

  assign nom_in = '{baud_r_presc, sync_jump_width, time_segment1,
                    time_segment2, triple_sampling};
  // The data set has no triple sampling; storing a constant 0 lets the
  // DATA mux pass the shadow straight through with tsmp already forced low.
  assign fd_in  = '{fd_baud_r_presc, fd_sync_jump_width, fd_time_segment1,
                    fd_time_segment2, 1'b0};

  assign brs_ok = sample_point && brs_field && sampled_bit && fdf &&
                  en_FD_bit_rate_change;

`ifdef CAN_FD_BRS_WATCHDOG_EN
  can_brs_watchdog #(
    .MAX_DATA_BITS(MAX_DATA_BITS)
  ) u_watchdog (
    .clk          (clk),
    .rst          (rst),
    .clear        (brs_switch_d),
    .active       (state_q == DATA),
    .sample_point (sample_point),
    .expire       (wd_expire)
  );
`else
  logic [WD_CNT_W-1:0] unused_wd_budget;
  assign unused_wd_budget = WD_CNT_W'(MAX_DATA_BITS);
  assign wd_expire        = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    nom_d         = nom_q;
    fd_d          = fd_q;
    brs_timeout_d = 1'b0;

    if (state_q == IDLE) begin
      nom_d = nom_in;
      fd_d  = fd_in;
    end

    case (state_q)
      IDLE: begin
        if (!rx_idle) state_d = NOMINAL;
      end
      NOMINAL: begin
        // An error frame outranks both bus-idle and the BRS sample point.
        if (go_error_frame)  state_d = NOMINAL;
        else if (rx_idle)    state_d = IDLE;
        else if (brs_ok)     state_d = DATA;
      end
      DATA: begin
        if (go_error_frame)  state_d = NOMINAL;
        else if (rx_idle)    state_d = IDLE;
        else if ((sample_point && crc_delim_field) || wd_expire) begin
          state_d       = NOMINAL;
          brs_timeout_d = wd_expire;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so new timing lands one clk after the
    // qualifying sample point; shadows feed from their current value, which
    // puts an IDLE config change two clks out.
    btl_d        = (state_d == DATA) ? fd_q : nom_q;
    data_phase_d = (state_d == DATA);
    brs_switch_d = (state_q == NOMINAL) && (state_d == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      nom_q         <= '0;
      fd_q          <= '0;
      btl_q         <= '0;
      data_phase_q  <= 1'b0;
      brs_switch_q  <= 1'b0;
      brs_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      nom_q         <= nom_d;
      fd_q          <= fd_d;
      btl_q         <= btl_d;
      data_phase_q  <= data_phase_d;
      brs_switch_q  <= brs_switch_d;
      brs_timeout_q <= brs_timeout_d;
    end
  end

  assign btl_baud_r_presc    = btl_q.presc;
  assign btl_sync_jump_width = btl_q.sjw;
  assign btl_time_segment1   = btl_q.tseg1;
  assign btl_time_segment2   = btl_q.tseg2;
  assign btl_triple_sampling = btl_q.tsmp;
  assign data_phase          = data_phase_q;
  assign brs_switch          = brs_switch_q;
  assign brs_timeout         = brs_timeout_q;

endmodule

// File: tb/tb_can_fd_brs_ctrl.sv
// Self-checking bench for can_fd_brs_ctrl: a directed vector table, hand
// sequences for frozen configuration and the watchdog, then randomized
// stimulus compared against a frame-level reference model.
module tb_can_fd_brs_ctrl;

  localparam int unsigned TB_MAX = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] baud_r_presc, fd_baud_r_presc;
  logic [1:0] sync_jump_width, fd_sync_jump_width;
  logic [3:0] time_segment1, fd_time_segment1;
  logic [2:0] time_segment2, fd_time_segment2;
  logic       triple_sampling, en_FD_bit_rate_change;
  logic       rx_idle, fdf, brs_field, crc_delim_field;
  logic       sample_point, sampled_bit, go_error_frame;
  logic [5:0] btl_baud_r_presc;
  logic [1:0] btl_sync_jump_width;
  logic [3:0] btl_time_segment1;
  logic [2:0] btl_time_segment2;
  logic       btl_triple_sampling, data_phase, brs_switch, brs_timeout;

  always #5 clk = ~clk;

  can_fd_brs_ctrl #(.MAX_DATA_BITS(TB_MAX)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .baud_r_presc          (baud_r_presc),
    .sync_jump_width       (sync_jump_width),
    .time_segment1         (time_segment1),
    .time_segment2         (time_segment2),
    .triple_sampling       (triple_sampling),
    .fd_baud_r_presc       (fd_baud_r_presc),
    .fd_sync_jump_width    (fd_sync_jump_width),
    .fd_time_segment1      (fd_time_segment1),
    .fd_time_segment2      (fd_time_segment2),
    .en_FD_bit_rate_change (en_FD_bit_rate_change),
    .rx_idle               (rx_idle),
    .fdf                   (fdf),
    .brs_field             (brs_field),
    .crc_delim_field       (crc_delim_field),
    .sample_point          (sample_point),
    .sampled_bit           (sampled_bit),
    .go_error_frame        (go_error_frame),
    .btl_baud_r_presc      (btl_baud_r_presc),
    .btl_sync_jump_width   (btl_sync_jump_width),
    .btl_time_segment1     (btl_time_segment1),
    .btl_time_segment2     (btl_time_segment2),
    .btl_triple_sampling   (btl_triple_sampling),
    .data_phase            (data_phase),
    .brs_switch            (brs_switch),
    .brs_timeout           (brs_timeout)
  );

  typedef struct packed {
    logic [5:0] presc;
    logic [1:0] sjw;
    logic [3:0] tseg1;
    logic [2:0] tseg2;
    logic       tsmp;
  } tset_t;

  typedef struct packed {
    tset_t btl;
    logic  dp;
    logic  sw;
    logic  to;
  } out_t;

  localparam tset_t NOM_T = '{presc: 6'd9, sjw: 2'd1, tseg1: 4'd12, tseg2: 3'd5, tsmp: 1'b1};
  localparam tset_t FD_T  = '{presc: 6'd1, sjw: 2'd0, tseg1: 4'd4,  tseg2: 3'd2, tsmp: 1'b0};

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t act;
    act = {btl_baud_r_presc, btl_sync_jump_width, btl_time_segment1,
           btl_time_segment2, btl_triple_sampling, data_phase, brs_switch,
           brs_timeout};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got presc=%0d sjw=%0d tseg1=%0d tseg2=%0d tsmp=%0b dp=%0b sw=%0b to=%0b, expected presc=%0d sjw=%0d tseg1=%0d tseg2=%0d tsmp=%0b dp=%0b sw=%0b to=%0b",
               name, act.btl.presc, act.btl.sjw, act.btl.tseg1, act.btl.tseg2,
               act.btl.tsmp, act.dp, act.sw, act.to, exp.btl.presc, exp.btl.sjw,
               exp.btl.tseg1, exp.btl.tseg2, exp.btl.tsmp, exp.dp, exp.sw, exp.to);
    end
  endtask

  task automatic set_cfg(input tset_t n, input tset_t f);
    baud_r_presc       = n.presc;
    sync_jump_width    = n.sjw;
    time_segment1      = n.tseg1;
    time_segment2      = n.tseg2;
    triple_sampling    = n.tsmp;
    fd_baud_r_presc    = f.presc;
    fd_sync_jump_width = f.sjw;
    fd_time_segment1   = f.tseg1;
    fd_time_segment2   = f.tseg2;
  endtask

  task automatic set_in(input logic r, input logic idle, input logic sp,
                        input logic brs, input logic sbit, input logic ff,
                        input logic en, input logic crc, input logic gerr);
    rst = r; rx_idle = idle; sample_point = sp; brs_field = brs;
    sampled_bit = sbit; fdf = ff; en_FD_bit_rate_change = en;
    crc_delim_field = crc; go_error_frame = gerr;
  endtask

  // sel: 0 = all-zero timing, 1 = nominal set, 2 = data set
  function automatic out_t mk_out(input int sel, input logic dp,
                                  input logic sw, input logic to);
    out_t o;
    o.btl = (sel == 1) ? NOM_T : (sel == 2) ? FD_T : '0;
    o.dp = dp; o.sw = sw; o.to = to;
    return o;
  endfunction

  typedef struct {
    logic r, idle, sp, brs, sbit, ff, en, crc, gerr;
    int   sel;
    logic dp, sw;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic idle, input logic sp,
                             input logic brs, input logic sbit, input logic ff,
                             input logic en, input logic crc, input logic gerr,
                             input int sel, input logic dp, input logic sw);
    vec_t x;
    x.r = r; x.idle = idle; x.sp = sp; x.brs = brs; x.sbit = sbit; x.ff = ff;
    x.en = en; x.crc = crc; x.gerr = gerr; x.sel = sel; x.dp = dp; x.sw = sw;
    return x;
  endfunction

  // Reference model: tracks "inside a frame" and "fast bit rate" as two
  // booleans, a frame-start snapshot of both configurations, and the number
  // of data-phase sample points seen.
  bit          m_busy, m_fast;
  tset_t       m_nom, m_fd;
  int unsigned m_cnt;
  out_t        m_exp;

  task automatic model_step();
    bit    busy_n, fast_n, to, wd;
    tset_t nin, fin;
    nin = {baud_r_presc, sync_jump_width, time_segment1, time_segment2, triple_sampling};
    fin = {fd_baud_r_presc, fd_sync_jump_width, fd_time_segment1, fd_time_segment2, 1'b0};
    if (rst) begin
      m_busy = 0; m_fast = 0; m_nom = '0; m_fd = '0; m_cnt = 0; m_exp = '0;
    end else begin
      busy_n = m_busy; fast_n = m_fast; to = 0; wd = 0;
`ifdef CAN_FD_BRS_WATCHDOG_EN
      wd = m_fast && sample_point && (m_cnt + 1 >= TB_MAX);
`endif
      if (!m_busy) begin
        busy_n = !rx_idle;
      end else if (go_error_frame) begin
        fast_n = 0;
      end else if (rx_idle) begin
        busy_n = 0; fast_n = 0;
      end else if (m_fast) begin
        if ((sample_point && crc_delim_field) || wd) fast_n = 0;
        to = wd;
      end else if (sample_point && brs_field && sampled_bit && fdf &&
                   en_FD_bit_rate_change) begin
        fast_n = 1;
      end
      m_exp.btl = fast_n ? m_fd : m_nom;
      m_exp.dp  = fast_n;
      m_exp.sw  = fast_n && !m_fast;
      m_exp.to  = to;
      if (m_fast && sample_point && m_cnt < 1023) m_cnt++;
      if (fast_n && !m_fast) m_cnt = 0;
      if (!m_busy) begin m_nom = nin; m_fd = fin; end
      m_busy = busy_n; m_fast = fast_n;
    end
  endtask

  initial begin
    set_cfg(NOM_T, FD_T);
    set_in(1, 1, 0, 0, 0, 1, 1, 0, 0);

    //        r idle sp brs bit fdf en crc gerr sel dp sw
    tbl.push_back(v(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // reset
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // shadow load
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0)); // nominal out
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0)); // frame start
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 1, 0, 0, 2, 1, 1)); // BRS switch
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 1, 0)); // hold data
    tbl.push_back(v(0, 0, 1, 0, 0, 1, 1, 0, 0, 2, 1, 0)); // data bit
    tbl.push_back(v(0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0)); // CRC delim
    tbl.push_back(v(0, 0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0)); // dominant BRS
    tbl.push_back(v(0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0)); // fdf=0
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0)); // en=0
    tbl.push_back(v(0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0)); // no sample point
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0)); // error on BRS
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 1, 0, 0, 2, 1, 1)); // switch again
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0)); // error abort
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 1, 0, 0, 2, 1, 1)); // switch again
    tbl.push_back(v(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0)); // bus idle in DATA
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0)); // new frame
    tbl.push_back(v(0, 0, 1, 1, 1, 1, 1, 0, 0, 2, 1, 1)); // switch
    tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // reset in DATA

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].r, tbl[i].idle, tbl[i].sp, tbl[i].brs, tbl[i].sbit,
             tbl[i].ff, tbl[i].en, tbl[i].crc, tbl[i].gerr);
      tick();
      check($sformatf("table[%0d]", i), mk_out(tbl[i].sel, tbl[i].dp, tbl[i].sw, 1'b0));
    end

    // Frozen configuration: a mid-frame write waits for IDLE plus two clks.
    set_in(0, 1, 0, 0, 0, 1, 1, 0, 0);
    tick(); tick();
    set_in(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    baud_r_presc = 6'd20;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frozen_in_frame", mk_out(1, 0, 0, 0));
    end
    rx_idle = 1'b1;
    tick(); check("frozen_enter_idle", mk_out(1, 0, 0, 0));
    tick(); check("frozen_shadow_load", mk_out(1, 0, 0, 0));
    tick();
    begin
      out_t e;
      e = mk_out(1, 0, 0, 0);
      e.btl.presc = 6'd20;
      check("frozen_released", e);
    end
    baud_r_presc = 6'd9;
    tick(); tick();

    // Watchdog budget of TB_MAX data-phase sample points.
    set_in(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    set_in(0, 0, 1, 1, 1, 1, 1, 0, 0);
    tick();
    check("wd_switch", mk_out(2, 1, 1, 0));
    set_in(0, 0, 1, 0, 1, 1, 1, 0, 0);
    for (int i = 1; i < TB_MAX; i++) begin
      tick();
      check($sformatf("wd_bit%0d", i), mk_out(2, 1, 0, 0));
    end
    tick();
`ifdef CAN_FD_BRS_WATCHDOG_EN
    check("wd_expire", mk_out(1, 0, 0, 1));
    set_in(0, 0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    check("wd_pulse_end", mk_out(1, 0, 0, 0));
`else
    check("wd_absent", mk_out(2, 1, 0, 0));
    set_in(0, 0, 1, 0, 1, 1, 1, 1, 0);
    tick();
    check("wd_absent_crc", mk_out(1, 0, 0, 0));
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      set_in((i == 0) || ($urandom_range(0, 199) == 0),
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 3) != 0,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 39) == 0);
      baud_r_presc       = 6'($urandom);
      sync_jump_width    = 2'($urandom);
      time_segment1      = 4'($urandom);
      time_segment2      = 3'($urandom);
      triple_sampling    = 1'($urandom);
      fd_baud_r_presc    = 6'($urandom);
      fd_sync_jump_width = 2'($urandom);
      fd_time_segment1   = 4'($urandom);
      fd_time_segment2   = 3'($urandom);
      model_step();
      tick();
      check($sformatf("rand[%0d]", i), m_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
